// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-master request arbiter in front of the SDRAM controller.
// Master 0 is the CPU bus, master 1 the video/DMA fetch engine. The winning
// request is latched and held on the controller port until s_ready. Then
// the granted master gets a one-cycle ready and, for reads, registered data.
// A DONE cycle always follows s_ready, so the controller sees valid low in
// the cycle after it signals ready.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for alternating grants
// on contention. The default build gives master 0 fixed priority.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m0_valid,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_din,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  output logic [DATA_WIDTH-1:0]   m0_dout,
  output logic                    m0_ready,
  input  logic                    m1_valid,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_din,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  output logic [DATA_WIDTH-1:0]   m1_dout,
  output logic                    m1_ready,
  output logic                    s_valid,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_din,
  output logic [DATA_WIDTH/8-1:0] s_wmask,
  input  logic [DATA_WIDTH-1:0]   s_dout,
  input  logic                    s_ready,
  output logic                    grant
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_e;

  arb_state_e              state_q;
  logic                    s_valid_q;
  logic [ADDR_WIDTH-1:0]   s_addr_q;
  logic [DATA_WIDTH-1:0]   s_din_q;
  logic [MASK_WIDTH-1:0]   s_wmask_q;
  logic [DATA_WIDTH-1:0]   m0_dout_q;
  logic [DATA_WIDTH-1:0]   m1_dout_q;
  logic                    m0_ready_q;
  logic                    m1_ready_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    winner_d;

  // Pick the master that wins arbitration if the IDLE edge sees a request.
  // With no requester the value is unused, so it parks on last_grant.
  always_comb begin
    winner_d = last_grant_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    if (m0_valid && m1_valid) begin
      winner_d = ~last_grant_q;
    end else if (m0_valid) begin
      winner_d = 1'b0;
    end else if (m1_valid) begin
      winner_d = 1'b1;
    end
`else
    if (m0_valid) begin
      winner_d = 1'b0;
    end else if (m1_valid) begin
      winner_d = 1'b1;
    end
`endif
  end

  // Arbitration FSM with all controller- and master-facing outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      s_valid_q    <= 1'b0;
      s_addr_q     <= '0;
      s_din_q      <= '0;
      s_wmask_q    <= '0;
      m0_dout_q    <= '0;
      m1_dout_q    <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_valid || m1_valid) begin
            s_valid_q <= 1'b1;
            grant_q   <= winner_d;
            s_addr_q  <= winner_d ? m1_addr  : m0_addr;
            s_din_q   <= winner_d ? m1_din   : m0_din;
            s_wmask_q <= winner_d ? m1_wmask : m0_wmask;
            state_q   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (s_ready) begin
            s_valid_q <= 1'b0;
            if (s_wmask_q == '0) begin
              if (grant_q) begin
                m1_dout_q <= s_dout;
              end else begin
                m0_dout_q <= s_dout;
              end
            end
            if (grant_q) begin
              m1_ready_q <= 1'b1;
            end else begin
              m0_ready_q <= 1'b1;
            end
            state_q <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          m0_ready_q   <= 1'b0;
          m1_ready_q   <= 1'b0;
          last_grant_q <= grant_q;
          state_q      <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_din    = s_din_q;
  assign s_wmask  = s_wmask_q;
  assign m0_dout  = m0_dout_q;
  assign m1_dout  = m1_dout_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter. Stimulus pushes the
// expected completion of every transfer into a queue. A monitor pops it
// whenever either ready pulses. A controller model answers s_valid after a
// programmable latency and checks hold/spacing rules on the controller port.
module tb_sdram_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [24:0] m0_addr, m1_addr;
  logic [31:0] m0_din, m1_din;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [24:0] s_addr;
  logic [31:0] s_din;
  logic [3:0]  s_wmask;
  logic [31:0] s_dout;
  logic        s_ready;
  logic        grant;

  typedef struct {
    int          master;
    logic [31:0] m0Dout;
    logic [31:0] m1Dout;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelDout [2];
  int          checks = 0;
  int          errors = 0;
  int          ctrlLatency = 2;
  int          contSeq [4];

  sdram_arbiter #(.ADDR_WIDTH(25), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_din(m0_din), .m0_wmask(m0_wmask),
    .m0_dout(m0_dout), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_din(m1_din), .m1_wmask(m1_wmask),
    .m1_dout(m1_dout), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_din(s_din), .s_wmask(s_wmask),
    .s_dout(s_dout), .s_ready(s_ready), .grant(grant)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data the controller model returns for a given address.
  function automatic logic [31:0] respData(input logic [24:0] addr);
    if (addr == 25'h0000100) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0000, addr[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic setMaster(input int m, input logic v, input logic [24:0] a,
                           input logic [31:0] d, input logic [3:0] w);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_din = d; m0_wmask = w;
    end else begin
      m1_valid = v; m1_addr = a; m1_din = d; m1_wmask = w;
    end
  endtask

  // Record the completion a transfer must produce, updating the dout model.
  task automatic pushExpect(input int m, input logic [24:0] a, input logic [3:0] w);
    exp_t e;
    if (w == 4'b0000) modelDout[m] = respData(a);
    e.master = m;
    e.m0Dout = modelDout[0];
    e.m1Dout = modelDout[1];
    expQ.push_back(e);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_ready || m1_ready) && n < 200);
    if (!(m0_ready || m1_ready)) checkOutput({name, "Timeout"}, 32'd0, 32'd1);
  endtask

  // One complete single-master transfer, checking the controller port one
  // cycle after the request is raised.
  task automatic applyStimulus(input int m, input logic [24:0] a, input logic [31:0] d,
                               input logic [3:0] w, input int latency);
    ctrlLatency = latency;
    @(negedge clk);
    pushExpect(m, a, w);
    setMaster(m, 1'b1, a, d, w);
    @(negedge clk);
    checkOutput("sValidLatency", 32'(s_valid), 32'd1);
    checkOutput("sAddr", 32'(s_addr), 32'(a));
    checkOutput("sDin", s_din, d);
    checkOutput("sWmask", 32'(s_wmask), 32'(w));
    checkOutput("grantBusy", 32'(grant), 32'(m));
    waitReady("transfer");
    setMaster(m, 1'b0, 25'h0, 32'h0, 4'h0);
  endtask

  // Controller model: counts s_valid cycles, pulses s_ready after the
  // programmed latency, and checks request hold and post-ready spacing.
  initial begin
    int          busyCnt;
    int          sinceReady;
    logic        justReady;
    logic [24:0] capAddr;
    logic [31:0] capDin;
    logic [3:0]  capWmask;
    busyCnt = 0; sinceReady = 99; capAddr = '0; capDin = '0; capWmask = '0;
    s_ready = 1'b0;
    s_dout  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        s_ready = 1'b0; s_dout = '0; busyCnt = 0; sinceReady = 99;
      end else begin
        justReady = s_ready;
        if (justReady) begin
          s_ready = 1'b0; s_dout = '0; busyCnt = 0; sinceReady = 1;
        end else if (sinceReady < 99) begin
          sinceReady++;
        end
        if (sinceReady == 1 || sinceReady == 2)
          checkOutput("sValidLowAfterReady", 32'(s_valid), 32'd0);
        if (!justReady && s_valid) begin
          busyCnt++;
          if (busyCnt == 1) begin
            capAddr = s_addr; capDin = s_din; capWmask = s_wmask;
          end else begin
            checkOutput("holdAddr", 32'(s_addr), 32'(capAddr));
            checkOutput("holdDin", s_din, capDin);
            checkOutput("holdWmask", 32'(s_wmask), 32'(capWmask));
          end
          if (busyCnt >= ctrlLatency) begin
            s_ready = 1'b1;
            s_dout  = respData(capAddr);
          end
        end
      end
    end
  end

  // Monitor: on every ready pulse pop the scoreboard and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && (m0_ready || m1_ready)) begin
        checkOutput("readyOneHot", 32'(m0_ready & m1_ready), 32'd0);
        checkOutput("readyAfterSReady", 32'(s_ready), 32'd1);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedReady", 32'(m1_ready), 32'hFFFFFFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("readyMaster", 32'(m1_ready), 32'(e.master));
          checkOutput("grantAtReady", 32'(grant), 32'(e.master));
          checkOutput("m0Dout", m0_dout, e.m0Dout);
          checkOutput("m1Dout", m1_dout, e.m1Dout);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    contSeq = '{0, 1, 0, 1};
`else
    contSeq = '{0, 0, 0, 0};
`endif
    modelDout[0] = '0;
    modelDout[1] = '0;
    resetn = 1'b0;
    setMaster(0, 1'b0, 25'h0, 32'h0, 4'h0);
    setMaster(1, 1'b0, 25'h0, 32'h0, 4'h0);
    #3;
    checkOutput("rstSValid", 32'(s_valid), 32'd0);
    checkOutput("rstSAddr", 32'(s_addr), 32'd0);
    checkOutput("rstSDin", s_din, 32'd0);
    checkOutput("rstSWmask", 32'(s_wmask), 32'd0);
    checkOutput("rstReady", 32'({m0_ready, m1_ready}), 32'd0);
    checkOutput("rstM0Dout", m0_dout, 32'd0);
    checkOutput("rstM1Dout", m1_dout, 32'd0);
    checkOutput("rstGrant", 32'(grant), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    $display("[TB] read, master 0 only");
    applyStimulus(0, 25'h0000100, 32'h0, 4'b0000, 5);
    $display("[TB] write, master 1 only");
    applyStimulus(1, 25'h0000200, 32'h12345678, 4'b0011, 4);
    $display("[TB] contention, four transfers");
    ctrlLatency = 2;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      pushExpect(contSeq[i], (contSeq[i] == 1) ? 25'h0000080 : 25'h0000040, 4'b0000);
    setMaster(0, 1'b1, 25'h0000040, 32'h0, 4'b0000);
    setMaster(1, 1'b1, 25'h0000080, 32'h0, 4'b0000);
    for (int i = 0; i < 4; i++) waitReady("contention");
    setMaster(0, 1'b0, 25'h0, 32'h0, 4'h0);
    setMaster(1, 1'b0, 25'h0, 32'h0, 4'h0);
    $display("[TB] back-to-back spacing");
    ctrlLatency = 3;
    @(negedge clk);
    pushExpect(0, 25'h0000200, 4'b0000);
    setMaster(0, 1'b1, 25'h0000200, 32'h0, 4'b0000);
    waitReady("spacingFirst");
    checkOutput("sValidDone", 32'(s_valid), 32'd0);
    pushExpect(0, 25'h0000300, 4'b0000);
    m0_addr = 25'h0000300;
    @(negedge clk);
    checkOutput("sValidIdleGap", 32'(s_valid), 32'd0);
    @(negedge clk);
    checkOutput("sValidRise", 32'(s_valid), 32'd1);
    checkOutput("sAddrSecond", 32'(s_addr), 32'h300);
    waitReady("spacingSecond");
    setMaster(0, 1'b0, 25'h0, 32'h0, 4'h0);
    $display("[TB] reset mid-transfer");
    ctrlLatency = 20;
    @(negedge clk);
    setMaster(0, 1'b1, 25'h0000340, 32'h0, 4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("busyBeforeReset", 32'(s_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("sValidAsyncReset", 32'(s_valid), 32'd0);
    checkOutput("noReadyOnReset", 32'({m0_ready, m1_ready}), 32'd0);
    checkOutput("m0DoutReset", m0_dout, 32'd0);
    modelDout[0] = '0;
    modelDout[1] = '0;
    setMaster(0, 1'b0, 25'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("noReadyInReset", 32'({m0_ready, m1_ready}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("idleAfterReset", 32'(s_valid), 32'd0);
    ctrlLatency = 2;
    pushExpect(0, 25'h0000040, 4'b0000);
    setMaster(0, 1'b1, 25'h0000040, 32'h0, 4'b0000);
    setMaster(1, 1'b1, 25'h0000080, 32'h0, 4'b0000);
    @(negedge clk);
    checkOutput("firstGrantAfterReset", 32'(grant), 32'd0);
    waitReady("postReset");
    setMaster(0, 1'b0, 25'h0, 32'h0, 4'h0);
    setMaster(1, 1'b0, 25'h0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    checkOutput("finalIdle", 32'(s_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-master request arbiter that sits directly upstream of the SDRAM controller and drives its valid/ready request port.
- Master 0 is the CPU bus; master 1 is the video/DMA fetch engine.
- Registers the winning request, holds it stable until the controller completes it, then returns read data and a one-cycle ready to that master.
- Enforces the controller's rule that valid is low in the cycle after ready.

Parameters:
- ADDR_WIDTH, 25, byte address width of the controller port (26 for 64 MB parts).
- DATA_WIDTH, 32, data width; wmask width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, shared with the SDRAM controller
- resetn  input  1  reset, asynchronous, active-low
- m0_valid  input  1  master 0 request; held until m0_ready
- m0_addr  input  ADDR_WIDTH  master 0 byte address
- m0_din  input  DATA_WIDTH  master 0 write data
- m0_wmask  input  DATA_WIDTH/8  master 0 byte enables; all-zero means read
- m0_dout  output  DATA_WIDTH  master 0 read data, registered
- m0_ready  output  1  master 0 completion pulse
- m1_valid, m1_addr, m1_din, m1_wmask, m1_dout, m1_ready  same as the m0_* ports, for master 1
- s_valid  output  1  request to the controller
- s_addr  output  ADDR_WIDTH  to the controller
- s_din  output  DATA_WIDTH  to the controller
- s_wmask  output  DATA_WIDTH/8  to the controller
- s_dout  input  DATA_WIDTH  controller read data; stable while s_ready=1
- s_ready  input  1  controller completion; one-cycle pulse
- grant  output  1  index of the master owning the current or last transfer

Behaviour:
- Clocking and reset: all state is on clk; resetn is asynchronous, active-low.
- Reset values:
  - state=ARB_IDLE; s_valid=0; s_addr=0; s_din=0; s_wmask=0.
  - m0_ready=0, m1_ready=0; m0_dout=0, m1_dout=0.
  - grant=0; last_grant=1, so master 0 wins the first contention.
- Reset mid-transfer: the abort is immediate, s_valid drops asynchronously, and no ready is issued. The controller has its own reset and is not relied on to finish.
- ARB_IDLE:
  - If neither valid is high, stay.
  - Otherwise select a winner (see selection rule).
  - On the clock edge: latch the winner's addr/din/wmask into s_addr/s_din/s_wmask, set s_valid=1, grant=winner, and go to ARB_BUSY.
  - Latency: valid sampled high at edge N gives s_valid=1 from N+1.
- ARB_BUSY:
  - s_* held constant; requests from either master are ignored.
  - When s_ready=1 at an edge:
    - s_valid goes to 0.
    - If the latched s_wmask==0, m<grant>_dout<=s_dout; otherwise that dout is unchanged.
    - m<grant>_ready goes to 1 and the state moves to ARB_DONE.
  - No timeout; waits indefinitely.
- ARB_DONE:
  - m<grant>_ready=1 for exactly this cycle; s_valid=0.
  - Always return to ARB_IDLE and update last_grant=grant.
  - The non-granted ready is never asserted.
- Master rules:
  - valid is dropped in the cycle following its ready pulse.
  - addr/din/wmask only need to be stable in the cycle valid is first sampled, because the arbiter latches them.
  - A master dropping valid while ARB_BUSY is a protocol violation. The arbiter still completes the transfer and pulses ready.
- Throughput and spacing:
  - Minimum spacing between consecutive s_valid rising edges is 2 cycles after s_ready (DONE, then IDLE).
  - This guarantees the controller sees valid=0 while its ready is high.
- Simultaneous events:
  - Both valids high in ARB_IDLE: resolved by the selection rule.
  - A valid rising during ARB_DONE is not seen until ARB_IDLE.
- m0_dout and m1_dout hold their last read value indefinitely.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined: on contention in ARB_IDLE the winner is ~last_grant (alternating). A single requester always wins regardless of last_grant.
- Undefined: fixed priority, master 0 always wins contention. Master 1 is served only when m0_valid=0 in ARB_IDLE, and starvation of master 1 is permitted. last_grant is still maintained but unused.

Test Plan:
- Read, master 0 only:
  - Stimulus: m0 read at addr 0x0000100; controller model returns 0xDEADBEEF with s_ready 5 cycles after s_valid.
  - Required: s_valid high 1 cycle after request with s_addr=0x0000100 and s_wmask=0. m0_ready pulses once, 1 cycle after s_ready, with m0_dout=0xDEADBEEF. m1_dout stays 0.
- Write, master 1 only:
  - Stimulus: m1 write with din=0x12345678 and wmask=4'b0011.
  - Required: s_din/s_wmask match and are held through BUSY. m1_ready pulses once. m1_dout is unchanged. grant=1.
- Contention with SDRAM_ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both masters request continuously for 4 transfers.
  - Required: grant sequence 0,1,0,1.
- Contention without the macro:
  - Stimulus: same as above.
  - Required: grant sequence 0,0,0,0; m1_ready never asserted while m0_valid stays high.
- Back-to-back spacing:
  - Stimulus: m0 re-requests immediately after ready.
  - Required: s_valid=0 in the s_ready cycle+1 and cycle+2, rising no earlier than cycle+3.
- Reset mid-transfer:
  - Stimulus: resetn low during ARB_BUSY.
  - Required: s_valid=0 asynchronously; no ready pulse; after release, the first contention is granted to master 0.
